pimac_driver: RTL and testbench

Initiator-side sequencer for the PiMAC multiply-accumulate unit. Accepts operand bytes over a valid/ready stream, assembles a, b and c, presents them to the MAC and waits a fixed latency. It then captures the 8-bit MAC result and returns it over a second valid/ready stream. It sits between the chip's byte-wide pin interface (or an on-chip host) and the PiMAC operand and result ports.

---
 rtl/pimac_driver.sv | 78 +++++++
 tb/tb_pimac_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pimac_driver.sv
// Byte-stream sequencer for the PiMAC: assembles a/b/c, waits out the MAC
// latency, returns the result. Define PIMAC_DRV_OPCNT_EN to add op_count.
module pimac_driver #(
  parameter int unsigned MAC_LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [3:0] mac_a,
  output logic [3:0] mac_b,
  output logic [3:0] mac_c,
  input  logic [7:0] mac_result,
  output logic       res_valid,
  output logic [7:0] res_data,
  input  logic       res_ready
`ifdef PIMAC_DRV_OPCNT_EN
  ,
  output logic [7:0] op_count
`endif
);

  typedef enum logic [1:0] {S_AB, S_C, S_WAIT, S_RES} state_t;

  state_t     state;
  logic [3:0] cnt;

  assign in_ready  = (state == S_AB) || (state == S_C);
  assign res_valid = (state == S_RES);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_AB;
      cnt      <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_c    <= '0;
      res_data <= '0;
    end else begin
      case (state)
        S_AB: if (in_valid) begin
          mac_a <= in_data[3:0];
          mac_b <= in_data[7:4];
          state <= S_C;
        end
        S_C: if (in_valid) begin
          mac_c <= in_data[3:0];
          cnt   <= 4'(MAC_LATENCY);
          state <= S_WAIT;
        end
        // Capture one edge after the count expires, so a MAC with
        // MAC_LATENCY register stages has settled its output.
        S_WAIT: begin
          if (cnt == 4'd0) begin
            res_data <= mac_result;
            state    <= S_RES;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RES: if (res_ready) state <= S_AB;
        default: state <= S_AB;
      endcase
    end
  end

`ifdef PIMAC_DRV_OPCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (state == S_RES && res_ready) begin
      op_count <= op_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pimac_driver.sv
// Directed + random bench for pimac_driver: two instances (latency 1 and 3),
// each fed by a pipelined PiMAC model; expected results from a*b+c arithmetic.
module tb_pimac_driver;

  logic       clk = 1'b0;
  logic       rst_n     [2];
  logic       in_valid  [2];
  logic [7:0] in_data   [2];
  logic       in_ready  [2];
  logic [3:0] mac_a     [2];
  logic [3:0] mac_b     [2];
  logic [3:0] mac_c     [2];
  logic [7:0] mac_result[2];
  logic       res_valid [2];
  logic [7:0] res_data  [2];
  logic       res_ready [2];
`ifdef PIMAC_DRV_OPCNT_EN
  logic [7:0] op_count  [2];
`endif

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt [2];

  always #5 clk = ~clk;

  pimac_driver #(.MAC_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .mac_a(mac_a[0]), .mac_b(mac_b[0]), .mac_c(mac_c[0]),
    .mac_result(mac_result[0]), .res_valid(res_valid[0]), .res_data(res_data[0]),
    .res_ready(res_ready[0])
`ifdef PIMAC_DRV_OPCNT_EN
    , .op_count(op_count[0])
`endif
  );

  pimac_driver #(.MAC_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .mac_a(mac_a[1]), .mac_b(mac_b[1]), .mac_c(mac_c[1]),
    .mac_result(mac_result[1]), .res_valid(res_valid[1]), .res_data(res_data[1]),
    .res_ready(res_ready[1])
`ifdef PIMAC_DRV_OPCNT_EN
    , .op_count(op_count[1])
`endif
  );

  // PiMAC models: one register stage for latency 1, three for latency 3.
  logic [7:0] pipe1;
  logic [7:0] pipe3 [3];
  always_ff @(posedge clk) begin
    pipe1    <= 8'(mac_a[0]) * 8'(mac_b[0]) + 8'(mac_c[0]);
    pipe3[0] <= 8'(mac_a[1]) * 8'(mac_b[1]) + 8'(mac_c[1]);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mac_result[0] = pipe1;
  assign mac_result[1] = pipe3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input int sel);
`ifdef PIMAC_DRV_OPCNT_EN
    check("op_count", 32'(op_count[sel]), 32'(exp_cnt[sel]));
`else
    if (sel < 0) $display("unused %0d", sel);
`endif
  endtask

  task automatic wait_ready(input int sel);
    int n = 0;
    while (in_ready[sel] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready[sel]), 32'd1);
  endtask

  task automatic do_op(input int sel, input logic [7:0] b0, input logic [7:0] b1,
                       input int hold);
    int lat = (sel == 0) ? 1 : 3;
    int n;
    logic [7:0] e = 8'(int'(b0[3:0]) * int'(b0[7:4]) + int'(b1[3:0]));
    wait_ready(sel);
    in_valid[sel] = 1'b1;
    in_data[sel]  = b0;
    @(negedge clk);
    check("byte0_a", 32'(mac_a[sel]), 32'(b0[3:0]));
    check("byte0_b", 32'(mac_b[sel]), 32'(b0[7:4]));
    check("ready_s_c", 32'(in_ready[sel]), 32'd1);
    in_data[sel] = b1;
    @(negedge clk);
    in_valid[sel] = 1'b0;
    check("byte1_c", 32'(mac_c[sel]), 32'(b1[3:0]));
    n = 0;
    while (res_valid[sel] !== 1'b1 && n < 40) begin
      check("ready_wait_low", 32'(in_ready[sel]), 32'd0);
      @(negedge clk);
      n++;
    end
    check("res_latency", 32'(n), 32'(lat + 1));
    check("res_data", 32'(res_data[sel]), 32'(e));
    for (int h = 0; h < hold; h++) begin
      in_valid[sel] = 1'b1;
      in_data[sel]  = 8'h99;
      @(negedge clk);
      check("bp_valid", 32'(res_valid[sel]), 32'd1);
      check("bp_data", 32'(res_data[sel]), 32'(e));
      check("bp_ready", 32'(in_ready[sel]), 32'd0);
      check("bp_abc", {20'd0, mac_a[sel], mac_b[sel], mac_c[sel]},
            {20'd0, b0[3:0], b0[7:4], b1[3:0]});
    end
    in_valid[sel]  = 1'b0;
    res_ready[sel] = 1'b1;
    @(negedge clk);
    res_ready[sel] = 1'b0;
    exp_cnt[sel]++;
    check("post_ready", 32'(in_ready[sel]), 32'd1);
    check("post_valid", 32'(res_valid[sel]), 32'd0);
    check("post_a_kept", 32'(mac_a[sel]), 32'(b0[3:0]));
    check_cnt(sel);
  endtask

  task automatic pulse_reset(input int sel);
    rst_n[sel] = 1'b0;
    @(negedge clk);
    rst_n[sel] = 1'b1;
    exp_cnt[sel] = '0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; in_valid[s] = 1'b0; in_data[s] = '0; res_ready[s] = 1'b0;
      exp_cnt[s] = '0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b1;
      check("rst_ready", 32'(in_ready[s]), 32'd1);
      check("rst_valid", 32'(res_valid[s]), 32'd0);
      check("rst_data", 32'(res_data[s]), 32'd0);
      check("rst_abc", {20'd0, mac_a[s], mac_b[s], mac_c[s]}, 32'd0);
      check_cnt(s);
    end

    do_op(0, 8'h53, 8'h07, 0);
    check("basic_22", 32'(res_data[0]), 32'h16);
    do_op(0, 8'hFF, 8'hAF, 0);
    check("ext_c", 32'(mac_c[0]), 32'hF);
    do_op(0, 8'h00, 8'h00, 0);
    do_op(0, 8'h53, 8'h07, 5);

    // Reset in the middle of an operation.
    wait_ready(0);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h53;
    @(negedge clk);
    in_valid[0] = 1'b0;
    pulse_reset(0);
    check("midrst_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_ab", {24'd0, mac_a[0], mac_b[0]}, 32'd0);
    check("midrst_valid", 32'(res_valid[0]), 32'd0);
    do_op(0, 8'h21, 8'h01, 0);
    check("midrst_res", 32'(res_data[0]), 32'h03);

    do_op(1, 8'h53, 8'h07, 2);
    do_op(1, 8'hFF, 8'hAF, 0);
    for (int i = 0; i < 20; i++)
      do_op(1, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    pulse_reset(0);
    for (int i = 0; i < 257; i++)
      do_op(0, 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
`ifdef PIMAC_DRV_OPCNT_EN
    check("opcnt_wrap", 32'(op_count[0]), 32'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
